// File: rtl/hicore_bjp_issue.sv
// hicore_bjp_issue: in-order issue queue for branch/jump ops.
// Buffers dispatched ops and wakes operands by ROB-pointer tags on the write-back bus.
// Issues only the oldest entry to the BJP unit, with a precomputed link value of pc+4.
// Ops that carry a dispatch-time exception drain with cancel set.

`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_ROB_PTR_SIZE
`define HiCore_ROB_PTR_SIZE 4
`endif
`ifndef HiCore_ISSUE2ALU_SIZE
`define HiCore_ISSUE2ALU_SIZE 10
`endif

module hicore_bjp_issue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              disp_valid,
   output logic                              disp_ready,
   input  logic [`HiCore_ISSUE2ALU_SIZE-1:0] disp_info,
   input  logic [`HiCore_REG_SIZE-1:0]       disp_pc,
   input  logic                              disp_excp,
   input  logic                              disp_rs1_rdy,
   input  logic                              disp_rs2_rdy,
   input  logic [`HiCore_ROB_PTR_SIZE-1:0]   disp_rs1_tag,
   input  logic [`HiCore_ROB_PTR_SIZE-1:0]   disp_rs2_tag,
   input  logic [`HiCore_REG_SIZE-1:0]       disp_rs1_data,
   input  logic [`HiCore_REG_SIZE-1:0]       disp_rs2_data,
   input  logic                              wb_wen,
   input  logic [`HiCore_ROB_PTR_SIZE-1:0]   wb_ptr,
   input  logic [`HiCore_REG_SIZE-1:0]       wb_data,
   output logic                              i_issue2bjp_valid,
   input  logic                              i_issue2bjp_ready,
   output logic                              i_issue2bjp_cancel,
   output logic [`HiCore_REG_SIZE-1:0]       bjp_rd_result,
   output logic [`HiCore_ISSUE2ALU_SIZE-1:0] bjp_info,
   output logic [`HiCore_REG_SIZE-1:0]       bjp_rs1_data,
   output logic [`HiCore_REG_SIZE-1:0]       bjp_rs2_data,
   input  logic                              flush
);

   localparam int REG_W  = `HiCore_REG_SIZE;
   localparam int ROB_W  = `HiCore_ROB_PTR_SIZE;
   localparam int INFO_W = `HiCore_ISSUE2ALU_SIZE;

   // Per-entry storage; the link value is stored already incremented so a
   // reset entry reads back as zero on every output.
   logic [DEPTH-1:0]  ent_vld;
   logic [DEPTH-1:0]  ent_excp;
   logic [DEPTH-1:0]  ent_rs1_rdy;
   logic [DEPTH-1:0]  ent_rs2_rdy;
   logic [ROB_W-1:0]  ent_rs1_tag  [DEPTH];
   logic [ROB_W-1:0]  ent_rs2_tag  [DEPTH];
   logic [REG_W-1:0]  ent_rs1_data [DEPTH];
   logic [REG_W-1:0]  ent_rs2_data [DEPTH];
   logic [REG_W-1:0]  ent_link     [DEPTH];
   logic [INFO_W-1:0] ent_info     [DEPTH];

   // Head/tail carry one wrap bit above the index bits.
   logic [PTR_W:0]    head;
   logic [PTR_W:0]    tail;
   logic [PTR_W-1:0]  hidx;
   logic [PTR_W-1:0]  tidx;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              head_rdy;

   // Operand captured straight off the bus when dispatch and write-back meet.
   logic              byp_rs1;
   logic              byp_rs2;
   logic [REG_W-1:0]  disp_link;

   assign hidx  = head[PTR_W-1:0];
   assign tidx  = tail[PTR_W-1:0];
   assign empty = (head == tail);
   assign full  = (head[PTR_W] != tail[PTR_W]) && (hidx == tidx);

   assign disp_ready = ~full;
   assign push       = disp_valid & ~full & ~flush;

   assign head_rdy          = ent_excp[hidx] | (ent_rs1_rdy[hidx] & ent_rs2_rdy[hidx]);
   assign i_issue2bjp_valid = ~empty & ~flush & head_rdy;
   assign pop               = i_issue2bjp_valid & i_issue2bjp_ready;

   assign i_issue2bjp_cancel = ent_excp[hidx];
   assign bjp_rd_result      = ent_link[hidx];
   assign bjp_info           = ent_info[hidx];
   assign bjp_rs1_data       = ent_rs1_data[hidx];
   assign bjp_rs2_data       = ent_rs2_data[hidx];

   assign byp_rs1   = wb_wen & ~disp_rs1_rdy & (wb_ptr == disp_rs1_tag);
   assign byp_rs2   = wb_wen & ~disp_rs2_rdy & (wb_ptr == disp_rs2_tag);
   assign disp_link = disp_pc + REG_W'(4);

   // Queue state: reset/flush emptying, operand wakeup, push at tail, pop at head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head        <= '0;
         tail        <= '0;
         ent_vld     <= '0;
         ent_excp    <= '0;
         ent_rs1_rdy <= '0;
         ent_rs2_rdy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_rs1_tag[i]  <= '0;
            ent_rs2_tag[i]  <= '0;
            ent_rs1_data[i] <= '0;
            ent_rs2_data[i] <= '0;
            ent_link[i]     <= '0;
            ent_info[i]     <= '0;
         end
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         ent_vld <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && wb_wen) begin
               if (!ent_rs1_rdy[i] && (ent_rs1_tag[i] == wb_ptr)) begin
                  ent_rs1_rdy[i]  <= 1'b1;
                  ent_rs1_data[i] <= wb_data;
               end
               if (!ent_rs2_rdy[i] && (ent_rs2_tag[i] == wb_ptr)) begin
                  ent_rs2_rdy[i]  <= 1'b1;
                  ent_rs2_data[i] <= wb_data;
               end
            end
         end
         if (push) begin
            ent_vld[tidx]      <= 1'b1;
            ent_excp[tidx]     <= disp_excp;
            ent_info[tidx]     <= disp_info;
            ent_link[tidx]     <= disp_link;
            ent_rs1_tag[tidx]  <= disp_rs1_tag;
            ent_rs2_tag[tidx]  <= disp_rs2_tag;
            ent_rs1_rdy[tidx]  <= disp_rs1_rdy | byp_rs1;
            ent_rs2_rdy[tidx]  <= disp_rs2_rdy | byp_rs2;
            ent_rs1_data[tidx] <= byp_rs1 ? wb_data : disp_rs1_data;
            ent_rs2_data[tidx] <= byp_rs2 ? wb_data : disp_rs2_data;
            tail               <= tail + (PTR_W+1)'(1);
         end
         if (pop) begin
            ent_vld[hidx] <= 1'b0;
            head          <= head + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_hicore_bjp_issue.sv
// Directed bench for hicore_bjp_issue with a scoreboard of expected issues.

`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_ROB_PTR_SIZE
`define HiCore_ROB_PTR_SIZE 4
`endif
`ifndef HiCore_ISSUE2ALU_SIZE
`define HiCore_ISSUE2ALU_SIZE 10
`endif

module tb_hicore_bjp_issue;

   localparam int DEPTH  = 4;
   localparam int REG_W  = `HiCore_REG_SIZE;
   localparam int ROB_W  = `HiCore_ROB_PTR_SIZE;
   localparam int INFO_W = `HiCore_ISSUE2ALU_SIZE;

   logic              clk;
   logic              rst;
   logic              disp_valid;
   logic              disp_ready;
   logic [INFO_W-1:0] disp_info;
   logic [REG_W-1:0]  disp_pc;
   logic              disp_excp;
   logic              disp_rs1_rdy;
   logic              disp_rs2_rdy;
   logic [ROB_W-1:0]  disp_rs1_tag;
   logic [ROB_W-1:0]  disp_rs2_tag;
   logic [REG_W-1:0]  disp_rs1_data;
   logic [REG_W-1:0]  disp_rs2_data;
   logic              wb_wen;
   logic [ROB_W-1:0]  wb_ptr;
   logic [REG_W-1:0]  wb_data;
   logic              i_issue2bjp_valid;
   logic              i_issue2bjp_ready;
   logic              i_issue2bjp_cancel;
   logic [REG_W-1:0]  bjp_rd_result;
   logic [INFO_W-1:0] bjp_info;
   logic [REG_W-1:0]  bjp_rs1_data;
   logic [REG_W-1:0]  bjp_rs2_data;
   logic              flush;

   typedef struct {
      logic [REG_W-1:0]  link;
      logic [INFO_W-1:0] info;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic              cancel;
      logic              chk_ops;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   hicore_bjp_issue #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .disp_valid         (disp_valid),
      .disp_ready         (disp_ready),
      .disp_info          (disp_info),
      .disp_pc            (disp_pc),
      .disp_excp          (disp_excp),
      .disp_rs1_rdy       (disp_rs1_rdy),
      .disp_rs2_rdy       (disp_rs2_rdy),
      .disp_rs1_tag       (disp_rs1_tag),
      .disp_rs2_tag       (disp_rs2_tag),
      .disp_rs1_data      (disp_rs1_data),
      .disp_rs2_data      (disp_rs2_data),
      .wb_wen             (wb_wen),
      .wb_ptr             (wb_ptr),
      .wb_data            (wb_data),
      .i_issue2bjp_valid  (i_issue2bjp_valid),
      .i_issue2bjp_ready  (i_issue2bjp_ready),
      .i_issue2bjp_cancel (i_issue2bjp_cancel),
      .bjp_rd_result      (bjp_rd_result),
      .bjp_info           (bjp_info),
      .bjp_rs1_data       (bjp_rs1_data),
      .bjp_rs2_data       (bjp_rs2_data),
      .flush              (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
      end
   endtask

   // Drive one dispatch beat (called just after a rising edge); the scoreboard
   // entry is recorded only when the occupancy model says there is room.
   task automatic push_op(input logic [REG_W-1:0] pc, input logic [INFO_W-1:0] info,
                          input logic excp,
                          input logic r1rdy, input logic [ROB_W-1:0] r1tag, input logic [REG_W-1:0] r1d,
                          input logic r2rdy, input logic [ROB_W-1:0] r2tag, input logic [REG_W-1:0] r2d,
                          input logic [REG_W-1:0] e1, input logic [REG_W-1:0] e2,
                          input logic chk_ops);
      exp_t e;
      logic room;
      room = (sb.size() < DEPTH);
      chk("disp_ready", disp_ready, room);
      disp_valid    = 1'b1;
      disp_pc       = pc;
      disp_info     = info;
      disp_excp     = excp;
      disp_rs1_rdy  = r1rdy;
      disp_rs1_tag  = r1tag;
      disp_rs1_data = r1d;
      disp_rs2_rdy  = r2rdy;
      disp_rs2_tag  = r2tag;
      disp_rs2_data = r2d;
      if (room) begin
         e.link    = pc + REG_W'(4);
         e.info    = info;
         e.rs1     = e1;
         e.rs2     = e2;
         e.cancel  = excp;
         e.chk_ops = chk_ops;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      disp_valid = 1'b0;
   endtask

   task automatic push_rdy(input logic [REG_W-1:0] pc, input logic [INFO_W-1:0] info,
                           input logic [REG_W-1:0] d1, input logic [REG_W-1:0] d2);
      push_op(pc, info, 1'b0, 1'b1, '0, d1, 1'b1, '0, d2, d1, d2, 1'b1);
   endtask

   task automatic drain();
      i_issue2bjp_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("drain_left", sb.size(), 0);
      @(negedge clk);
      chk("drain_valid", i_issue2bjp_valid, 1'b0);
      @(posedge clk); #1;
      i_issue2bjp_ready = 1'b0;
   endtask

   // Every accepted issue is matched against the oldest expected op.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && i_issue2bjp_valid && i_issue2bjp_ready) begin
         chk("issue_expected", (sb.size() > 0), 1'b1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("iss_link", bjp_rd_result, e.link);
            chk("iss_info", bjp_info, e.info);
            chk("iss_cancel", i_issue2bjp_cancel, e.cancel);
            if (e.chk_ops) begin
               chk("iss_rs1", bjp_rs1_data, e.rs1);
               chk("iss_rs2", bjp_rs2_data, e.rs2);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_info = '0; disp_pc = '0;
      disp_excp = 1'b0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
      disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rs1_data = '0; disp_rs2_data = '0;
      wb_wen = 1'b0; wb_ptr = '0; wb_data = '0; i_issue2bjp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_disp_ready", disp_ready, 1'b1);
      chk("rst_valid", i_issue2bjp_valid, 1'b0);
      chk("rst_cancel", i_issue2bjp_cancel, 1'b0);
      chk("rst_rd_result", bjp_rd_result, 0);
      chk("rst_info", bjp_info, 0);
      chk("rst_rs1", bjp_rs1_data, 0);
      chk("rst_rs2", bjp_rs2_data, 0);
      @(posedge clk); #1;

      // single op, issues the cycle after push
      i_issue2bjp_ready = 1'b1;
      push_rdy(32'h100, 10'h1A3, 32'h1111_1111, 32'h2222_2222);
      @(negedge clk);
      chk("single_valid", i_issue2bjp_valid, 1'b1);
      chk("single_link", bjp_rd_result, 32'h104);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_empty", i_issue2bjp_valid, 1'b0);
      @(posedge clk); #1;
      i_issue2bjp_ready = 1'b0;

      // fill, one pop, then wrap through 8 ops in order
      for (int i = 0; i < 4; i++)
         push_rdy(32'(i * 4), 10'(i * 7 + 1), 32'(32'hA000 + i), 32'(32'hB000 + i));
      chk("full_ready", disp_ready, 1'b0);
      i_issue2bjp_ready = 1'b1;
      @(posedge clk); #1;
      i_issue2bjp_ready = 1'b0;
      chk("after_pop_ready", disp_ready, 1'b1);
      i_issue2bjp_ready = 1'b1;
      for (int i = 4; i < 8; i++)
         push_rdy(32'(i * 4), 10'(i * 7 + 1), 32'(32'hA000 + i), 32'(32'hB000 + i));
      drain();

      // head waits on rs2 wakeup; younger ready op must not overtake
      push_op(32'h200, 10'h0A5, 1'b0, 1'b1, 4'd0, 32'h1234, 1'b0, 4'd5, 32'h0,
              32'h1234, 32'hDEAD, 1'b1);
      push_rdy(32'h204, 10'h033, 32'h3333, 32'h4444);
      @(negedge clk);
      chk("young_not_first", i_issue2bjp_valid, 1'b0);
      @(posedge clk); #1;
      wb_wen = 1'b1; wb_ptr = 4'd5; wb_data = 32'hDEAD;
      @(negedge clk);
      chk("no_wb_bypass", i_issue2bjp_valid, 1'b0);
      @(posedge clk); #1;
      wb_wen = 1'b0;
      @(negedge clk);
      chk("wake_valid", i_issue2bjp_valid, 1'b1);
      chk("wake_rs2", bjp_rs2_data, 32'hDEAD);
      chk("wake_link", bjp_rd_result, 32'h204);
      @(posedge clk); #1;
      drain();

      // dispatch-cycle bypass from the write-back bus
      i_issue2bjp_ready = 1'b1;
      wb_wen = 1'b1; wb_ptr = 4'd3; wb_data = 32'h55;
      push_op(32'h300, 10'h111, 1'b0, 1'b0, 4'd3, 32'h0, 1'b1, 4'd0, 32'h66,
              32'h55, 32'h66, 1'b1);
      wb_wen = 1'b0;
      @(negedge clk);
      chk("byp_valid", i_issue2bjp_valid, 1'b1);
      chk("byp_rs1", bjp_rs1_data, 32'h55);
      @(posedge clk); #1;
      drain();

      // exception op issues with cancel despite unready operands
      push_op(32'h400, 10'h2F0, 1'b1, 1'b0, 4'd7, 32'h0, 1'b0, 4'd8, 32'h0,
              32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("excp_valid", i_issue2bjp_valid, 1'b1);
      chk("excp_cancel", i_issue2bjp_cancel, 1'b1);
      @(posedge clk); #1;
      push_rdy(32'h404, 10'h0F0, 32'h7777, 32'h8888);
      drain();

      // flush with a concurrent dispatch: nothing pushed, queue empty
      for (int i = 0; i < 3; i++)
         push_rdy(32'(32'h500 + i * 4), 10'(i + 40), 32'(i), 32'(i + 100));
      flush = 1'b1;
      disp_valid = 1'b1; disp_pc = 32'h50C; disp_excp = 1'b0;
      disp_rs1_rdy = 1'b1; disp_rs2_rdy = 1'b1;
      @(negedge clk);
      chk("flush_valid", i_issue2bjp_valid, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0; disp_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("post_flush_ready", disp_ready, 1'b1);
      chk("post_flush_valid", i_issue2bjp_valid, 1'b0);
      @(posedge clk); #1;
      i_issue2bjp_ready = 1'b1;
      push_rdy(32'h600, 10'h155, 32'hC0DE, 32'hBEEF);
      drain();

      // asynchronous reset mid-stream
      push_rdy(32'h700, 10'h077, 32'h1, 32'h2);
      push_rdy(32'h704, 10'h078, 32'h3, 32'h4);
      @(negedge clk);
      chk("pre_rst_valid", i_issue2bjp_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", i_issue2bjp_valid, 1'b0);
      chk("async_rst_ready", disp_ready, 1'b1);
      chk("async_rst_link", bjp_rd_result, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", i_issue2bjp_valid, 1'b0);
      @(posedge clk); #1;
      i_issue2bjp_ready = 1'b1;
      push_rdy(32'h800, 10'h3FF, 32'h9999, 32'hAAAA);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
